// File: rtl/adder_skolem_sweep_checker.sv
// Exhaustive sweep of W-bit operand pairs through an external candidate block,
// checking every returned {carry,sum} against a + b and recording the first counterexample.
module adder_skolem_sweep_checker #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  output logic           cand_valid,
  input  logic           cand_ready,
  output logic [W-1:0]   cand_a,
  output logic [W-1:0]   cand_b,
  input  logic           rsp_valid,
  input  logic [W-1:0]   rsp_sum,
  input  logic           rsp_carry,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   fail_count,
  output logic [W-1:0]   cex_a,
  output logic [W-1:0]   cex_b,
  output logic           proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam logic [OW-1:0]  OCC_FULL = OW'(DEPTH);
  localparam logic [2*W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2*W-1:0]  cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [2*W:0]    fail_q, fail_d;
  logic [W-1:0]    cex_a_q, cex_a_d;
  logic [W-1:0]    cex_b_q, cex_b_d;
  logic            perr_q, perr_d;
  logic [2*W-1:0]  mem_q [DEPTH];

  logic            start_ok;
  logic            push;
  logic            pop;
  logic            cmp_en;
  logic            mismatch;
  logic [2*W-1:0]  head;
  logic [W:0]      head_sum;

  always_comb begin
    start_ok   = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    cand_valid = (state_q == S_SWEEP) && (occ_q < OCC_FULL);
    push       = cand_valid & cand_ready;
    pop        = rsp_valid & (occ_q != '0);
    head       = mem_q[rd_ptr_q];
    head_sum   = {1'b0, head[W-1:0]} + {1'b0, head[2*W-1:W]};
    // Stop-at-first mode keeps popping after the first failure but stops judging.
    cmp_en     = mode_q | (fail_q == '0);
    mismatch   = pop & cmp_en & ({rsp_carry, rsp_sum} != head_sum);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fail_d   = fail_q;
    cex_a_d  = cex_a_q;
    cex_b_d  = cex_b_q;
    perr_d   = perr_q;

    if (push) begin
      cnt_d    = cnt_q + (2*W)'(1);
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    if (mismatch) begin
      fail_d = fail_q + (2*W+1)'(1);
      if (fail_q == '0) begin
        cex_a_d = head[W-1:0];
        cex_b_d = head[2*W-1:W];
      end
    end

    perr_d = (start_ok ? 1'b0 : perr_q) | (rsp_valid & (occ_q == '0));

    if (start_ok) begin
      cnt_d   = '0;
      mode_d  = mode;
      fail_d  = '0;
      cex_a_d = '0;
      cex_b_d = '0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if ((push && (cnt_q == CNT_LAST)) || (mismatch && !mode_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (occ_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fail_q   <= '0;
      cex_a_q  <= '0;
      cex_b_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fail_q   <= fail_d;
      cex_a_q  <= cex_a_d;
      cex_b_q  <= cex_b_d;
      perr_q   <= perr_d;
    end
  end

  // Payload storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cnt_q;
  end

  always_comb begin
    cand_a     = cnt_q[W-1:0];
    cand_b     = cnt_q[2*W-1:W];
    busy       = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    pass       = (state_q == S_DONE) && (fail_q == '0);
    fail_count = fail_q;
    cex_a      = cex_a_q;
    cex_b      = cex_b_q;
    proto_err  = perr_q;
  end

endmodule

// File: tb/tb_adder_skolem_sweep_checker.sv
// Directed bench: a cycle-stepped candidate model answers issued assignments,
// while a queue scoreboard holds the expected enumeration order.
module tb_adder_skolem_sweep_checker;

  localparam int W     = 2;
  localparam int DEPTH = 4;
  localparam int N     = 1 << (2 * W);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic           cand_ready = 1'b0;
  logic           rsp_valid = 1'b0;
  logic [W-1:0]   rsp_sum = '0;
  logic           rsp_carry = 1'b0;
  logic           cand_valid;
  logic [W-1:0]   cand_a;
  logic [W-1:0]   cand_b;
  logic           busy;
  logic           done;
  logic           pass;
  logic [2*W:0]   fail_count;
  logic [W-1:0]   cex_a;
  logic [W-1:0]   cex_b;
  logic           proto_err;

  adder_skolem_sweep_checker #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_a     (cand_a),
    .cand_b     (cand_b),
    .rsp_valid  (rsp_valid),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .cex_a      (cex_a),
    .cex_b      (cex_b),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  due;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } flight_t;

  flight_t        inflight[$];
  logic [2*W-1:0] sb[$];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned issued = 0;
  int unsigned answered = 0;
  int unsigned steps = 0;
  int          corrupt = 0;
  bit          toggle_rdy = 1'b0;
  bit          stop_mode = 1'b0;
  bit          halted = 1'b0;
  bit          bad_now = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cand_valid"}, cand_valid, 0);
    check({tag, "_cand_a"}, cand_a, 0);
    check({tag, "_cand_b"}, cand_b, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_cex_a"}, cex_a, 0);
    check({tag, "_cex_b"}, cex_b, 0);
    check({tag, "_proto_err"}, proto_err, 0);
  endtask

  // Candidate model: answers the oldest in-flight assignment once its latency elapses.
  task automatic drive_rsp();
    flight_t    f;
    logic [W:0] r;
    rsp_valid = 1'b0;
    rsp_sum   = '0;
    rsp_carry = 1'b0;
    bad_now   = 1'b0;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      f = inflight.pop_front();
      r = {1'b0, f.a} + {1'b0, f.b};
      if (corrupt == 1 && f.a == W'(2) && f.b == W'(1)) begin
        r[0]    = ~r[0];
        bad_now = 1'b1;
      end
      if (corrupt == 2 && r[W]) begin
        r[W]    = 1'b0;
        bad_now = 1'b1;
      end
      rsp_valid = 1'b1;
      rsp_sum   = r[W-1:0];
      rsp_carry = r[W];
    end
  endtask

  task automatic step();
    logic [2*W-1:0] e;
    flight_t        f;
    int unsigned    occ;
    if (halted) check("valid_after_fail", cand_valid, 0);
    if (cand_valid && cand_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL issue_extra observed=%0d/%0d expected=none", cand_a, cand_b);
      end else begin
        e = sb.pop_front();
        check("issue_a", cand_a, e[W-1:0]);
        check("issue_b", cand_b, e[2*W-1:W]);
      end
      f.due = cyc + lat;
      f.a   = cand_a;
      f.b   = cand_b;
      inflight.push_back(f);
      issued++;
    end
    if (rsp_valid) begin
      answered++;
      if (bad_now && stop_mode) halted = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    occ = issued - answered;
    if (occ >= DEPTH) begin
      check("occ_max", occ, DEPTH);
      check("valid_low_full", cand_valid, 0);
    end
    drive_rsp();
    cand_ready = toggle_rdy ? ~cand_ready : 1'b1;
  endtask

  task automatic run_sweep(input bit m, input int unsigned l, input bit tog,
                           input int c, input int unsigned abort_at);
    sb.delete();
    inflight.delete();
    for (int i = 0; i < N; i++) sb.push_back((2*W)'(i));
    lat        = l;
    toggle_rdy = tog;
    corrupt    = c;
    stop_mode  = !m;
    halted     = 1'b0;
    issued     = 0;
    answered   = 0;
    cand_ready = 1'b1;
    mode       = m;
    start      = 1'b1;
    step();
    start = 1'b0;
    mode  = ~m;
    check("first_valid", cand_valid, 1);
    check("busy_after_start", busy, 1);
    check("perr_cleared", proto_err, 0);
    steps = 0;
    while (!done && steps < 500 && !(abort_at != 0 && issued >= abort_at)) begin
      step();
      steps++;
    end
    if (abort_at == 0) begin
      check("done_reached", done, 1);
      check("busy_at_done", busy, 0);
      check("valid_at_done", cand_valid, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray response while idle.
    rsp_valid = 1'b1;
    rsp_sum   = W'(3);
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    rsp_sum   = '0;
    check("idle_rsp_proto_err", proto_err, 1);
    check("idle_rsp_fail_count", fail_count, 0);
    check("idle_rsp_done", done, 0);

    // Full sweep, correct model, latency 1, always ready.
    run_sweep(1'b1, 1, 1'b0, 0, 0);
    check("t1_steps", steps, N + 1);
    check("t1_issued", issued, N);
    check("t1_pass", pass, 1);
    check("t1_fail_count", fail_count, 0);
    check("t1_proto_err", proto_err, 0);

    // Stop-at-first, sum corrupted at a=2 b=1.
    run_sweep(1'b0, 1, 1'b0, 1, 0);
    check("t2_cex_a", cex_a, 2);
    check("t2_cex_b", cex_b, 1);
    check("t2_fail_count", fail_count, 1);
    check("t2_pass", pass, 0);
    check("t2_halted", halted, 1);

    // Full sweep, carry forced low.
    run_sweep(1'b1, 1, 1'b0, 2, 0);
    check("t3_fail_count", fail_count, 6);
    check("t3_cex_a", cex_a, 3);
    check("t3_cex_b", cex_b, 1);
    check("t3_pass", pass, 0);

    // Long latency with toggling ready.
    run_sweep(1'b1, 6, 1'b1, 0, 0);
    check("t4_issued", issued, N);
    check("t4_answered", answered, N);
    check("t4_pass", pass, 1);
    check("t4_fail_count", fail_count, 0);

    // Asynchronous reset at cnt=9.
    run_sweep(1'b1, 1, 1'b0, 0, 9);
    check("t5_cnt_before_reset", {cand_b, cand_a}, 9);
    rst_n      = 1'b0;
    rsp_valid  = 1'b0;
    cand_ready = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b1, 1, 1'b0, 0, 0);
    check("t6_issued", issued, N);
    check("t6_pass", pass, 1);
    check("t6_fail_count", fail_count, 0);
    check("t6_proto_err", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_skolem_sweep_checker.md
# adder_skolem_sweep_checker

Parametrised, sequential successor to the combinational adder-relation formulas used in our Skolem-function benchmarks. Exhaustively enumerates every assignment of two W-bit universally quantified operands. Issues each assignment to an external candidate-function block and checks that the returned outputs satisfy the adder relation, {carry,sum} == a + b. Sits between the candidate generator under evaluation and the result-checking flow; reports pass/fail, failure count and the first counterexample.

## Interface
- W, default 4: operand width; legal range 1..8.
- DEPTH, default 4: maximum outstanding (issued, not yet answered) assignments; power of two, 2..16.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE; ignored otherwise.
- mode  in  1  sampled at start. 0 = stop at first failure; 1 = full sweep, count all failures.
- cand_valid  out  1  assignment offered.
- cand_ready  in  1  candidate block accepts assignment.
- cand_a  out  W  operand a of offered assignment.
- cand_b  out  W  operand b of offered assignment.
- rsp_valid  in  1  candidate response present; always accepted, no backpressure.
- rsp_sum  in  W  candidate sum bits.
- rsp_carry  in  1  candidate carry-out.
- busy  out  1  state is SWEEP or DRAIN.
- done  out  1  state is DONE.
- pass  out  1  valid when done; 1 iff fail_count == 0.
- fail_count  out  2W+1  number of failing responses checked; width holds 2^(2W), no saturation needed.
- cex_a, cex_b  out  W each  first failing assignment of the current sweep.
- proto_err  out  1  sticky; response arrived with nothing outstanding.

## Operation
- Reset: state IDLE, counter 0, FIFO empty. All outputs 0, including cand_valid, proto_err and fail_count.
- Sweep counter cnt, 2W bits: cand_a = cnt[W-1:0], cand_b = cnt[2W-1:W]. Enumeration runs from cnt 0 up to 2^(2W)-1.
- Start in IDLE or DONE:
  - clear cnt, fail_count, cex_a/b and proto_err;
  - latch mode;
  - enter SWEEP.
- SWEEP:
  - cand_valid = (occupancy < DEPTH), evaluated on registered occupancy.
  - A handshake (cand_valid & cand_ready) pushes {a,b} to an in-order FIFO and increments cnt.
  - Handshake at cnt = 2^(2W)-1 enters DRAIN.
- Response:
  - rsp_valid with occupancy > 0 pops the FIFO head and compares {rsp_carry,rsp_sum} against head a + b, computed at W+1 bits.
  - On mismatch, fail_count += 1. If it is the first failure of the sweep, cex_a/b capture the head operands.
- mode 0: the first mismatch (while in SWEEP) enters DRAIN. No further issues occur; later responses still pop the FIFO but are neither compared nor counted.
- DRAIN: cand_valid = 0. Leaves for DONE on the edge where post-update occupancy is 0.
- DONE: done = 1, pass = (fail_count == 0). Outputs hold until the next start or reset.
- Simultaneous push and pop in one cycle: occupancy unchanged. Full plus pop does not enable a push that cycle, because cand_valid uses registered occupancy.
- rsp_valid with occupancy 0, in any state: sets proto_err; the response is ignored.
- start during SWEEP/DRAIN: ignored.
- rst_n low mid-sweep: immediate return to reset values; no partial results retained.

## Timing
- cand_a/b come from registers; cand_valid is combinational from state and registered occupancy; no combinational path from cand_ready.
- Minimum candidate latency is 1 cycle: a response may arrive on the cycle after its handshake at the earliest.
- fail_count, cex and proto_err update on the edge at the end of the rsp_valid cycle.
- start edge to first cand_valid: 1 cycle.
- done asserts the cycle after the final pop.
- Best-case full sweep, always ready, latency-1 responses: 2^(2W) + 2 cycles from start to done.

## Test plan
- W=2, DEPTH=4, mode 1, correct model, latency 1, always ready → 16 issues, in order cnt 0..15; done=1, pass=1, fail_count=0, proto_err=0.
- mode 0, model corrupts sum only at a=2, b=1 → cex_a=2, cex_b=1, fail_count=1, pass=0. No handshake occurs after the failing response; done after the FIFO drains.
- mode 1, model forces carry=0 → fail_count=6, cex_a=3, cex_b=1 (first failure at cnt=7), pass=0.
- Response latency 6, cand_ready toggling every other cycle → occupancy never exceeds 4; cand_valid low while 4 are outstanding; all 16 checked; pass=1.
- rsp_valid pulse in IDLE → proto_err=1, fail_count=0. A following start clears proto_err.
- rst_n low at cnt=9 → all outputs 0 immediately. A new start runs the full 16-assignment sweep with pass=1.
